// File: rtl/tsip_timing_parser.sv
// TSIP primary-timing packet receiver: de-stuffs and validates frames from the UART byte
// stream, latches UTC fields, keeps packet statistics and a staleness watchdog.
module tsip_timing_parser #(
  parameter logic [7:0]  PKT_ID         = 8'h8F,
  parameter logic [7:0]  SUBCODE        = 8'hAB,
  parameter int unsigned PKT_LEN        = 17,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned TCNT_W         = 27
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  input  logic       i_wr,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_packet_dv,
  output logic       o_stale,
  output logic [7:0] o_year_h,
  output logic [7:0] o_year_l,
  output logic [7:0] o_month,
  output logic [7:0] o_day,
  output logic [7:0] o_hour,
  output logic [7:0] o_minutes,
  output logic [7:0] o_seconds
);

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;
  localparam int unsigned IW = $clog2(PKT_LEN + 2);
  localparam logic [IW-1:0] LEN_I = IW'(PKT_LEN);
  localparam logic [IW-1:0] LEN_SAT = IW'(PKT_LEN + 1);
  localparam logic [TCNT_W-1:0] TMAX = TCNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ID, S_DATA, S_DLE} state_t;

  state_t state, state_d;

  logic [7:0]    pkt_id;
  logic [IW-1:0] idx;
  logic          ovf;
  logic [7:0]    shadow [PKT_LEN];

  logic load_id, store_en, pkt_end, frame_err;
  logic good, bad, ctrl_clr;

  logic [7:0]        good_cnt, err_cnt;
  logic [TCNT_W-1:0] wdog;
  logic              ever_valid;
  logic [7:0]        rd_mux;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    load_id   = 1'b0;
    store_en  = 1'b0;
    pkt_end   = 1'b0;
    frame_err = 1'b0;
    if (i_rx_dv) begin
      unique case (state)
        S_IDLE: if (i_rx_byte == DLE) state_d = S_ID;
        S_ID: begin
          if (i_rx_byte == DLE || i_rx_byte == ETX) begin
            state_d = S_IDLE;
          end else begin
            load_id = 1'b1;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (i_rx_byte == DLE) state_d = S_DLE;
          else                  store_en = 1'b1;
        end
        S_DLE: begin
          if (i_rx_byte == DLE) begin
            store_en = 1'b1;
            state_d  = S_DATA;
          end else if (i_rx_byte == ETX) begin
            pkt_end = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Unpaired DLE: the byte is treated as the ID of a fresh packet.
            frame_err = 1'b1;
            load_id   = 1'b1;
            state_d   = S_DATA;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign good = pkt_end && (pkt_id == PKT_ID) && (shadow[0] == SUBCODE) &&
                (idx == LEN_I) && !ovf;
  assign bad  = (pkt_end && !good) || frame_err;
  assign ctrl_clr = i_wr && (i_addr == 7'h0A) && i_data[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pkt_id <= '0;
      idx    <= '0;
      ovf    <= 1'b0;
    end else if (load_id) begin
      pkt_id <= i_rx_byte;
      idx    <= '0;
      ovf    <= 1'b0;
    end else if (store_en) begin
      if (idx >= LEN_I) ovf <= 1'b1;
      if (idx != LEN_SAT) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (store_en && idx < LEN_I) shadow[idx] <= i_rx_byte;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_packet_dv <= 1'b0;
      o_seconds   <= '0;
      o_minutes   <= '0;
      o_hour      <= '0;
      o_day       <= '0;
      o_month     <= '0;
      o_year_h    <= '0;
      o_year_l    <= '0;
      ever_valid  <= 1'b0;
      wdog        <= '0;
      good_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      o_packet_dv <= good;
      if (good) begin
        o_seconds  <= shadow[10];
        o_minutes  <= shadow[11];
        o_hour     <= shadow[12];
        o_day      <= shadow[13];
        o_month    <= shadow[14];
        o_year_h   <= shadow[15];
        o_year_l   <= shadow[16];
        ever_valid <= 1'b1;
        wdog       <= '0;
      end else if (wdog != TMAX) begin
        wdog <= wdog + 1'b1;
      end
      if (ctrl_clr)  good_cnt <= '0;
      else if (good) good_cnt <= good_cnt + 1'b1;
      if (ctrl_clr)                    err_cnt <= '0;
      else if (bad && err_cnt != '1)   err_cnt <= err_cnt + 1'b1;
    end
  end

  assign o_stale = (wdog == TMAX);

  always_comb begin
    rd_mux = '0;
    unique case (i_addr)
      7'h00:   rd_mux = o_year_h;
      7'h01:   rd_mux = o_year_l;
      7'h02:   rd_mux = o_month;
      7'h03:   rd_mux = o_day;
      7'h04:   rd_mux = o_hour;
      7'h05:   rd_mux = o_minutes;
      7'h06:   rd_mux = o_seconds;
      7'h07:   rd_mux = {6'b0, o_stale, ever_valid};
      7'h08:   rd_mux = good_cnt;
      7'h09:   rd_mux = err_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_data <= '0;
    else       o_data <= rd_mux;
  end

endmodule

// File: tb/tb_tsip_timing_parser.sv
// Scoreboarded bench for tsip_timing_parser: stimulus queues expected packets and register
// reads; a monitor compares whenever o_packet_dv pulses or a read result is due.
module tb_tsip_timing_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx_dv = 1'b0;
  logic [7:0] i_rx_byte = '0;
  logic       i_wr = 1'b0;
  logic [6:0] i_addr = '0;
  logic [7:0] i_data = '0;
  logic [7:0] o_data;
  logic       o_packet_dv, o_stale;
  logic [7:0] o_year_h, o_year_l, o_month, o_day, o_hour, o_minutes, o_seconds;

  always #5 clk = ~clk;

  tsip_timing_parser #(.TIMEOUT_CYCLES(1000), .TCNT_W(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .i_wr(i_wr), .i_addr(i_addr), .i_data(i_data), .o_data(o_data),
    .o_packet_dv(o_packet_dv), .o_stale(o_stale),
    .o_year_h(o_year_h), .o_year_l(o_year_l), .o_month(o_month), .o_day(o_day),
    .o_hour(o_hour), .o_minutes(o_minutes), .o_seconds(o_seconds)
  );

  typedef struct {
    logic [7:0] s, m, h, d, mo, yh, yl;
  } exp_t;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] val;
  } rd_t;

  exp_t       pkt_q[$];
  rd_t        rd_q[$];
  logic [7:0] pl[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int commit_cyc = 0;
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (!rst && o_packet_dv) begin
        if (pkt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_packet_dv: got 1 expected 0 (no packet queued)");
        end else begin
          e = pkt_q.pop_front();
          chk("pkt_seconds", o_seconds, e.s);
          chk("pkt_minutes", o_minutes, e.m);
          chk("pkt_hour",    o_hour,    e.h);
          chk("pkt_day",     o_day,     e.d);
          chk("pkt_month",   o_month,   e.mo);
          chk("pkt_year_h",  o_year_h,  e.yh);
          chk("pkt_year_l",  o_year_l,  e.yl);
          chk("stale_at_commit", o_stale, 0);
          commit_cyc = cyc;
        end
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got 0x%0h expected none", o_data);
        end else begin
          r = rd_q.pop_front();
          chk($sformatf("reg_0x%02h", r.addr), o_data, r.val);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic clr);
    @(negedge clk);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    if (clr) begin
      i_wr   = 1'b1;
      i_addr = 7'h0A;
      i_data = 8'h01;
    end
    @(negedge clk);
    i_rx_dv = 1'b0;
    i_wr    = 1'b0;
  endtask

  task automatic make_pl(input logic [7:0] sub, input logic [7:0] s, m, h, d, mo, yh, yl);
    pl.delete();
    pl.push_back(sub);
    for (int i = 1; i <= 9; i++) pl.push_back(8'(i));
    pl.push_back(s);  pl.push_back(m);  pl.push_back(h);  pl.push_back(d);
    pl.push_back(mo); pl.push_back(yh); pl.push_back(yl);
  endtask

  task automatic send_body(input logic clr);
    foreach (pl[i]) begin
      send_byte(pl[i], 1'b0);
      if (pl[i] == 8'h10) send_byte(8'h10, 1'b0);
    end
    send_byte(8'h10, 1'b0);
    send_byte(8'h03, clr);
  endtask

  task automatic send_pkt(input logic [7:0] id, input logic clr);
    send_byte(8'h10, 1'b0);
    send_byte(id, 1'b0);
    send_body(clr);
  endtask

  task automatic expect_pkt(input logic [7:0] s, m, h, d, mo, yh, yl);
    exp_t e;
    e.s = s; e.m = m; e.h = h; e.d = d; e.mo = mo; e.yh = yh; e.yl = yl;
    pkt_q.push_back(e);
  endtask

  task automatic read_reg(input logic [6:0] a, input logic [7:0] v);
    rd_t r;
    @(negedge clk);
    i_addr = a;
    rd_req = 1'b1;
    r.addr = a;
    r.val  = v;
    rd_q.push_back(r);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_packet_dv"}, o_packet_dv, 0);
    chk({tag, "_stale"},     o_stale,     0);
    chk({tag, "_seconds"},   o_seconds,   0);
    chk({tag, "_year_h"},    o_year_h,    0);
    chk({tag, "_year_l"},    o_year_l,    0);
    chk({tag, "_hour"},      o_hour,      0);
    chk({tag, "_data"},      o_data,      0);
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Valid frame.
    make_pl(8'hAB, 8'h1E, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    expect_pkt(8'h1E, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    send_pkt(8'h8F, 1'b0);
    read_reg(7'h08, 8'h01);
    read_reg(7'h07, 8'h01);
    read_reg(7'h06, 8'h1E);
    read_reg(7'h00, 8'h07);
    read_reg(7'h01, 8'hE8);
    read_reg(7'h0A, 8'h00);
    read_reg(7'h7F, 8'h00);

    // Seconds of 0x10 goes on the wire stuffed.
    make_pl(8'hAB, 8'h10, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    expect_pkt(8'h10, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    send_pkt(8'h8F, 1'b0);
    read_reg(7'h08, 8'h02);
    read_reg(7'h09, 8'h00);

    // Rejected frames: wrong ID, wrong subcode, short, long.
    make_pl(8'hAB, 8'h1E, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    send_pkt(8'h8E, 1'b0);
    make_pl(8'hAC, 8'h1E, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    send_pkt(8'h8F, 1'b0);
    make_pl(8'hAB, 8'h1E, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    void'(pl.pop_back());
    send_pkt(8'h8F, 1'b0);
    make_pl(8'hAB, 8'h1E, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    pl.push_back(8'h55);
    send_pkt(8'h8F, 1'b0);
    read_reg(7'h09, 8'h04);
    read_reg(7'h08, 8'h02);
    chk("rejected_keeps_seconds", o_seconds, 8'h10);
    chk("rejected_keeps_year_l",  o_year_l,  8'hE8);

    // Framing error: the byte after an unpaired DLE starts a new, valid packet.
    send_byte(8'h10, 1'b0);
    send_byte(8'h8F, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h8F, 1'b0);
    make_pl(8'hAB, 8'h21, 8'h05, 8'h17, 8'h1F, 8'h0C, 8'h07, 8'hE9);
    expect_pkt(8'h21, 8'h05, 8'h17, 8'h1F, 8'h0C, 8'h07, 8'hE9);
    send_body(1'b0);
    read_reg(7'h09, 8'h05);
    read_reg(7'h08, 8'h03);

    // Staleness after silence.
    for (int i = 0; i < 2000 && !o_stale; i++) @(negedge clk);
    chk("stale_rise", o_stale, 1);
    chk("stale_delay_cycles", cyc - commit_cyc, 1000);
    read_reg(7'h07, 8'h03);
    make_pl(8'hAB, 8'h22, 8'h05, 8'h17, 8'h1F, 8'h0C, 8'h07, 8'hE9);
    expect_pkt(8'h22, 8'h05, 8'h17, 8'h1F, 8'h0C, 8'h07, 8'hE9);
    send_pkt(8'h8F, 1'b0);
    read_reg(7'h07, 8'h01);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h10, 1'b0);
      send_byte(8'h8E, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h03, 1'b0);
    end
    read_reg(7'h09, 8'hFF);
    read_reg(7'h08, 8'h04);

    // Counter clear on the same cycle as a commit.
    make_pl(8'hAB, 8'h30, 8'h31, 8'h01, 8'h02, 8'h03, 8'h07, 8'hEA);
    expect_pkt(8'h30, 8'h31, 8'h01, 8'h02, 8'h03, 8'h07, 8'hEA);
    send_pkt(8'h8F, 1'b1);
    read_reg(7'h08, 8'h00);
    read_reg(7'h09, 8'h00);

    // Reset mid-payload, then a full frame.
    send_byte(8'h10, 1'b0);
    send_byte(8'h8F, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    make_pl(8'hAB, 8'h1E, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    expect_pkt(8'h1E, 8'h2D, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8);
    send_pkt(8'h8F, 1'b0);
    read_reg(7'h08, 8'h01);
    read_reg(7'h09, 8'h00);
    read_reg(7'h07, 8'h01);

    repeat (4) @(negedge clk);
    chk("pkt_queue_drained", pkt_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL global_timeout: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
